// File: rtl/dbg_pkg.sv
// Shared definitions for the host debug/program-load unit:
// opcodes, reply bytes, FSM state encoding and opcode helpers.
package dbg_pkg;

  localparam logic [7:0] OP_WI   = 8'h01;
  localparam logic [7:0] OP_WD   = 8'h02;
  localparam logic [7:0] OP_RI   = 8'h03;
  localparam logic [7:0] OP_RD   = 8'h04;
  localparam logic [7:0] OP_RR   = 8'h05;
  localparam logic [7:0] OP_RUN  = 8'h06;
  localparam logic [7:0] OP_HALT = 8'h07;

  localparam logic [7:0] ACK_BYTE  = 8'hAA;
  localparam logic [7:0] ERR_BYTE  = 8'hEE;
  localparam logic [7:0] HALT_BYTE = 8'h5A;

  localparam int TIMEOUT_CYC_DEF = 100000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_WRITE,
    S_READ,
    S_SEND,
    S_RESP
  } state_e;

  function automatic logic op_has_addr(logic [7:0] op);
    return (op >= OP_WI) && (op <= OP_RR);
  endfunction

  function automatic logic op_is_write(logic [7:0] op);
    return (op == OP_WI) || (op == OP_WD);
  endfunction

endpackage

// File: rtl/dbg_tx_shift.sv
// Reply serializer: loads a 1- or 4-byte word, emits it LSB-first,
// each byte held on tx_data until tx_ready.
// Ports: clk, rstn, load/word/single (load request), tx_ready,
//        tx_valid/tx_data (registered stream), busy.
module dbg_tx_shift (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        single,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        busy
);

  logic [31:0] sh;
  logic [2:0]  left;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh       <= '0;
      left     <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      sh       <= word;
      left     <= single ? 3'd1 : 3'd4;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      sh       <= {8'h00, sh[31:8]};
      left     <= left - 3'd1;
      tx_valid <= (left != 3'd1);
    end
  end

  assign tx_data = sh[7:0];
  assign busy    = tx_valid;

endmodule

// File: rtl/debug_loader.sv
// Host-side debug/program-load unit: decodes framed byte commands,
// drives CPU debug write/read ports and CPU reset, replies on tx stream.
// Ports: clk, rstn; rx_valid/rx_data/rx_ready (command bytes);
//        tx_valid/tx_data/tx_ready (replies); cpu_rstn, cpu_stop;
//        inst_*/data_* debug write/read; rf_dcp_rd/rf_addr/rf_out.
module debug_loader
  import dbg_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        cpu_rstn,
  input  logic        cpu_stop,
  output logic        inst_we,
  output logic [7:0]  inst_addr,
  output logic [31:0] inst_in,
  output logic        data_we,
  output logic [7:0]  data_addr,
  output logic [31:0] data_in,
  output logic        rf_dcp_rd,
  output logic [4:0]  rf_addr,
  input  logic [31:0] inst_out,
  input  logic [31:0] data_out,
  input  logic [31:0] rf_out
);

  state_e      state, state_n;
  logic [7:0]  op, addr;
  logic [31:0] data, word, rd_word;
  logic [1:0]  cnt;
  logic [16:0] tmo;
  logic        pend, stop_q, live;
  logic        load, single, tx_busy;
  logic        acc, tmo_hit, stop_rise, in_frame;

  assign acc       = rx_valid & rx_ready;
  assign tmo_hit   = (tmo == 17'(TIMEOUT_CYC - 1));
  assign stop_rise = cpu_stop & ~stop_q & cpu_rstn;
  assign in_frame  = (state == S_GET_ADDR) || (state == S_GET_DATA);

  always_comb begin
    rd_word = rf_out;
    unique case (1'b1)
      (op == OP_RI): rd_word = inst_out;
      (op == OP_RD): rd_word = data_out;
      default:       rd_word = rf_out;
    endcase
  end

  always_comb begin
    state_n  = state;
    rx_ready = 1'b0;
    load     = 1'b0;
    single   = 1'b1;
    word     = {24'h0, ACK_BYTE};
    unique case (state)
      S_IDLE: begin
        if (pend) begin
          load    = 1'b1;
          word    = {24'h0, HALT_BYTE};
          state_n = S_RESP;
        end else begin
          rx_ready = live;
          if (rx_valid && live) begin
            if (op_has_addr(rx_data)) begin
              state_n = S_GET_ADDR;
            end else begin
              load    = 1'b1;
              state_n = S_RESP;
              if (rx_data != OP_RUN && rx_data != OP_HALT)
                word = {24'h0, ERR_BYTE};
            end
          end
        end
      end
      S_GET_ADDR: begin
        rx_ready = 1'b1;
        if (rx_valid)
          state_n = op_is_write(op) ? S_GET_DATA : S_READ;
        else if (tmo_hit)
          state_n = S_IDLE;
      end
      S_GET_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (cnt == 2'd3) state_n = S_WRITE;
        end else if (tmo_hit) begin
          state_n = S_IDLE;
        end
      end
      S_WRITE: begin
        load    = 1'b1;
        state_n = S_RESP;
        if (cpu_rstn) word = {24'h0, ERR_BYTE};
      end
      S_READ: begin
        load    = 1'b1;
        single  = 1'b0;
        word    = rd_word;
        state_n = S_SEND;
      end
      S_SEND, S_RESP: begin
        if (!tx_busy) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      op       <= '0;
      addr     <= '0;
      data     <= '0;
      cnt      <= '0;
      tmo      <= '0;
      pend     <= 1'b0;
      stop_q   <= 1'b0;
      live     <= 1'b0;
      cpu_rstn <= 1'b0;
    end else begin
      state  <= state_n;
      stop_q <= cpu_stop;
      live   <= 1'b1;
      if (state == S_IDLE && acc) begin
        op  <= rx_data;
        cnt <= '0;
        if (rx_data == OP_RUN)  cpu_rstn <= 1'b1;
        if (rx_data == OP_HALT) cpu_rstn <= 1'b0;
      end
      if (state == S_GET_ADDR && acc) addr <= rx_data;
      if (state == S_GET_DATA && acc) begin
        data <= {rx_data, data[31:8]};
        cnt  <= cnt + 2'd1;
      end
      if (in_frame && !acc) tmo <= tmo + 17'd1;
      else                  tmo <= '0;
      // A halt edge arriving while the notify goes out must not be lost.
      if (state == S_IDLE && acc && rx_data == OP_HALT) pend <= 1'b0;
      else if (stop_rise)                               pend <= 1'b1;
      else if (state == S_IDLE && pend)                 pend <= 1'b0;
    end
  end

  assign inst_we   = (state == S_WRITE) && (op == OP_WI) && !cpu_rstn;
  assign data_we   = (state == S_WRITE) && (op == OP_WD) && !cpu_rstn;
  assign inst_addr = addr;
  assign data_addr = addr;
  assign inst_in   = data;
  assign data_in   = data;
  assign rf_dcp_rd = (state == S_READ) && (op == OP_RR);
  assign rf_addr   = addr[4:0];

  dbg_tx_shift u_tx (
    .clk      (clk),
    .rstn     (rstn),
    .load     (load),
    .word     (word),
    .single   (single),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .busy     (tx_busy)
  );

endmodule

// File: tb/tb_debug_loader.sv
// Randomized self-checking bench for debug_loader with a CPU
// debug-port stub and a frame-level reference model.
module tb_debug_loader;
  import dbg_pkg::*;

  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        cpu_rstn, cpu_stop;
  logic        inst_we, data_we, rf_dcp_rd;
  logic [7:0]  inst_addr, data_addr;
  logic [31:0] inst_in, data_in;
  logic [4:0]  rf_addr;
  logic [31:0] inst_out, data_out, rf_out;

  logic [31:0] imem [256] = '{default: '0};
  logic [31:0] dmem [256] = '{default: '0};
  logic [31:0] rf   [32];
  logic [31:0] m_imem [256] = '{default: '0};
  logic [31:0] m_dmem [256] = '{default: '0};
  logic [31:0] m_rf   [32];
  logic        m_run;

  logic [7:0]  rxq [$];
  logic [40:0] wq  [$];
  logic [4:0]  rdq [$];
  logic        hold = 1'b0;
  logic [7:0]  hold_d = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debug_loader #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .cpu_rstn(cpu_rstn), .cpu_stop(cpu_stop),
    .inst_we(inst_we), .inst_addr(inst_addr), .inst_in(inst_in),
    .data_we(data_we), .data_addr(data_addr), .data_in(data_in),
    .rf_dcp_rd(rf_dcp_rd), .rf_addr(rf_addr),
    .inst_out(inst_out), .data_out(data_out), .rf_out(rf_out)
  );

  assign inst_out = imem[inst_addr];
  assign data_out = dmem[data_addr];
  assign rf_out   = rf[rf_addr];

  always @(posedge clk) begin
    if (inst_we) imem[inst_addr] <= inst_in;
    if (data_we) dmem[data_addr] <= data_in;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_valid && tx_ready) rxq.push_back(tx_data);
    if (inst_we) wq.push_back({1'b0, inst_addr, inst_in});
    if (data_we) wq.push_back({1'b1, data_addr, data_in});
    if (rf_dcp_rd) rdq.push_back(rf_addr);
    if (hold && rstn)
      check("tx_hold", 64'({tx_valid, tx_data}), 64'({1'b1, hold_d}));
    hold   = rstn && tx_valid && !tx_ready;
    hold_d = tx_data;
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 tx_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end, limit 1000000 ns");
    $fatal(1);
  end

  task automatic rst_check(input string tag);
    check({tag, "_ctl"}, 64'({cpu_rstn, rx_ready, tx_valid,
                              inst_we, data_we, rf_dcp_rd}), 64'(0));
    check({tag, "_addr"}, 64'({inst_addr, data_addr, rf_addr, tx_data}), 64'(0));
    check({tag, "_idat"}, 64'(inst_in), 64'(0));
    check({tag, "_ddat"}, 64'(data_in), 64'(0));
  endtask

  task automatic gap(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!rx_ready) check("rx_stall", 64'(rx_ready), 64'(1));
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic collect(input logic [7:0] ex [$]);
    int k = 0;
    while (rxq.size() < ex.size() && k < 400) begin
      @(posedge clk);
      k++;
    end
    repeat (8) @(posedge clk);
    #1;
    check("tx_count", 64'(rxq.size()), 64'(ex.size()));
    foreach (ex[i])
      if (i < rxq.size()) check("tx_byte", 64'(rxq[i]), 64'(ex[i]));
    rxq.delete();
  endtask

  task automatic do_frame(input logic [7:0] op, input logic [7:0] a,
                          input logic [31:0] d);
    logic [7:0]  ex [$];
    logic [31:0] w;
    logic [40:0] wexp;
    int          nw;
    nw   = 0;
    wexp = '0;
    w    = '0;
    case (op)
      8'h01, 8'h02: begin
        if (m_run) ex = {ERR_BYTE};
        else begin
          ex   = {ACK_BYTE};
          nw   = 1;
          wexp = {op == 8'h02, a, d};
        end
      end
      8'h03, 8'h04, 8'h05: begin
        if (op == 8'h03)      w = m_imem[a];
        else if (op == 8'h04) w = m_dmem[a];
        else                  w = m_rf[a[4:0]];
        ex = {w[7:0], w[15:8], w[23:16], w[31:24]};
      end
      8'h06: begin ex = {ACK_BYTE}; m_run = 1'b1; end
      8'h07: begin ex = {ACK_BYTE}; m_run = 1'b0; end
      default: ex = {ERR_BYTE};
    endcase
    send_byte(op);
    if (op >= 8'h01 && op <= 8'h05) begin
      gap($urandom_range(0, 2));
      send_byte(a);
    end
    if (op == 8'h01 || op == 8'h02)
      for (int i = 0; i < 4; i++) begin
        gap($urandom_range(0, 2));
        send_byte(d[8*i +: 8]);
      end
    collect(ex);
    check("strobes", 64'(wq.size()), 64'(nw));
    if (nw == 1 && wq.size() == 1) check("strobe", 64'(wq[0]), 64'(wexp));
    wq.delete();
    check("rf_sel", 64'(rdq.size()), 64'(op == 8'h05 ? 1 : 0));
    if (op == 8'h05 && rdq.size() == 1)
      check("rf_addr", 64'(rdq[0]), 64'(a[4:0]));
    rdq.delete();
    if (nw == 1) begin
      if (op == 8'h01) m_imem[a] = d;
      else             m_dmem[a] = d;
    end
    check("cpu_rstn", 64'(cpu_rstn), 64'(m_run));
  endtask

  initial begin
    logic [7:0]  q [$];
    logic [7:0]  op;
    logic [31:0] v;
    rstn = 1'b0; rx_valid = 1'b0; rx_data = '0; cpu_stop = 1'b0;
    m_run = 1'b0;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      if (i == 3) v = 32'h0000_0007;
      rf[i]   = v;
      m_rf[i] = v;
    end
    repeat (3) @(posedge clk);
    #1 rst_check("reset");
    rstn = 1'b1;
    gap(2);

    do_frame(OP_WI, 8'h05, 32'h1234_5678);
    do_frame(OP_WD, 8'h10, 32'hDEAD_BEEF);
    do_frame(OP_RD, 8'h10, 32'h0);
    do_frame(OP_RI, 8'h05, 32'h0);

    do_frame(OP_RUN, 8'h00, 32'h0);
    do_frame(OP_WD, 8'h00, 32'h0000_0001);
    cpu_stop = 1'b1;
    q = {HALT_BYTE};
    collect(q);
    cpu_stop = 1'b0;
    gap(2);

    do_frame(8'h09, 8'h00, 32'h0);
    do_frame(OP_RR, 8'h03, 32'h0);

    send_byte(OP_WI);
    send_byte(8'h02);
    send_byte(8'h11);
    gap(TMO + 10);
    check("tmo_tx", 64'(rxq.size()), 64'(0));
    check("tmo_we", 64'(wq.size()), 64'(0));
    do_frame(OP_HALT, 8'h00, 32'h0);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0, 8:    op = OP_WI;
        1:       op = OP_WD;
        2:       op = OP_RI;
        3, 9:    op = OP_RD;
        4:       op = OP_RR;
        5:       op = OP_RUN;
        6:       op = OP_HALT;
        default: op = 8'(8 + $urandom_range(0, 200));
      endcase
      do_frame(op, 8'($urandom_range(0, 255)), $urandom);
    end
    do_frame(OP_HALT, 8'h00, 32'h0);

    send_byte(OP_WI);
    send_byte(8'h07);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    check("pre_rst_addr", 64'(inst_addr), 64'(8'h07));
    #2 rstn = 1'b0;
    #1 rst_check("async_rst");
    rx_valid = 1'b0;
    m_run    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    gap(20);
    check("rst_we", 64'(wq.size()), 64'(0));
    check("rst_tx", 64'(rxq.size()), 64'(0));
    do_frame(OP_RI, 8'h07, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
